// File: rtl/vlsu_pkg.sv
// rtl/vlsu_pkg.sv - shared types and helpers for the vector load/store sequencer
// Contents: state_t (IDLE, ISSUE, DRAIN, DONE), ELEM_BYTES_DEF, vl_width().
// No ports (package).
package vlsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int ELEM_BYTES_DEF = 4;

  // Width needed to hold an element count of 0..max_vl inclusive.
  function automatic int vl_width(input int max_vl);
    return $clog2(max_vl + 1);
  endfunction

endpackage

// File: rtl/vlsu_seq_ctrl_if.sv
// rtl/vlsu_seq_ctrl_if.sv - scalar data-memory port between the sequencer and dmem
// Signals: mem_req_valid/ready/we/addr/wdata (request), mem_rsp_valid/rdata (load response).
// Modports: master (sequencer side), slave (memory side).
interface vlsu_seq_ctrl_if;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

endinterface

// File: rtl/vlsu_addr_gen.sv
// rtl/vlsu_addr_gen.sv - running-sum element address register
// Ports: clk, rst_n (async active-low), load (latch base/stride), step (advance one element),
//        base, stride (byte stride, used only with VLSU_STRIDE_EN), addr (current element address).
// Config: VLSU_STRIDE_EN selects the latched command stride as increment; otherwise ELEM_BYTES.
module vlsu_addr_gen
  import vlsu_pkg::*;
#(
  parameter int ELEM_BYTES = ELEM_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] base,
  input  logic [31:0] stride,
  output logic [31:0] addr
);

  logic [31:0] inc;

`ifdef VLSU_STRIDE_EN
  logic [31:0] stride_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride_q <= '0;
    end else if (load) begin
      stride_q <= stride;
    end
  end

  assign inc = stride_q;
`else
  logic unused_stride;

  assign unused_stride = ^stride;
  assign inc           = 32'(ELEM_BYTES);
`endif

  // Accumulating the increment replaces base + idx*inc; the 32-bit sum wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (load) begin
      addr <= base;
    end else if (step) begin
      addr <= addr + inc;
    end
  end

endmodule

// File: rtl/vlsu_seq_ctrl.sv
// rtl/vlsu_seq_ctrl.sv - vector load/store sequencer issuing per-element dmem requests
// Ports: clk, rst_n (async active-low); cmd_valid/ready/store/base/stride/vl (command in);
//        st_idx/st_data (VRF store read); mem (vlsu_seq_ctrl_if.master dmem port);
//        vrf_we/idx/wdata (load write-back); busy, done (one-cycle completion pulse).
// Config: VLSU_STRIDE_EN (in vlsu_addr_gen) enables strided addressing from cmd_stride.
module vlsu_seq_ctrl
  import vlsu_pkg::*;
#(
  parameter int MAX_VL     = 16,
  parameter int ELEM_BYTES = ELEM_BYTES_DEF,
  parameter int MAX_OUT    = 4,
  parameter int VL_W       = vl_width(MAX_VL)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_store,
  input  logic [31:0]         cmd_base,
  input  logic [31:0]         cmd_stride,
  input  logic [VL_W-1:0]     cmd_vl,
  output logic [3:0]          st_idx,
  input  logic [31:0]         st_data,
  vlsu_seq_ctrl_if.master     mem,
  output logic                vrf_we,
  output logic [3:0]          vrf_idx,
  output logic [31:0]         vrf_wdata,
  output logic                busy,
  output logic                done
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);

  state_t            state, state_nx;
  logic              store_q;
  logic [VL_W-1:0]   vl_q;
  logic [VL_W-1:0]   iss_cnt;
  logic [VL_W-1:0]   rsp_cnt;
  logic [OUT_W-1:0]  out_cnt;

  logic              accept;
  logic              slot_free;
  logic              req_valid;
  logic              xfer;
  logic              ld_xfer;
  logic              last_iss;
  logic              rsp_take;
  logic [VL_W-1:0]   vl_clamped;

  assign cmd_ready  = (state == ST_IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign vl_clamped = (cmd_vl > VL_W'(MAX_VL)) ? VL_W'(MAX_VL) : cmd_vl;

  // Stores never wait for responses, so only loads are throttled by outstanding slots.
  assign slot_free  = store_q || (out_cnt < OUT_W'(MAX_OUT));
  assign req_valid  = (state == ST_ISSUE) && (iss_cnt < vl_q) && slot_free;
  assign xfer       = req_valid && mem.mem_req_ready;
  assign ld_xfer    = xfer && !store_q;
  assign last_iss   = (iss_cnt + VL_W'(1)) == vl_q;

  // Responses only count while a load is in flight; strays after reset or during stores drop.
  assign rsp_take   = mem.mem_rsp_valid && !store_q &&
                      ((state == ST_ISSUE) || (state == ST_DRAIN));

  assign mem.mem_req_valid = req_valid;
  assign mem.mem_req_we    = store_q;
  assign mem.mem_req_wdata = req_valid ? st_data : '0;
  assign st_idx            = iss_cnt[3:0];

  assign vrf_we    = rsp_take;
  assign vrf_idx   = rsp_cnt[3:0];
  assign vrf_wdata = rsp_take ? mem.mem_rsp_rdata : '0;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  vlsu_addr_gen #(
    .ELEM_BYTES (ELEM_BYTES)
  ) u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .step   (xfer),
    .base   (cmd_base),
    .stride (cmd_stride),
    .addr   (mem.mem_req_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) state_nx = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (vl_q == '0) begin
          state_nx = ST_DONE;
        end else if (xfer && last_iss) begin
          state_nx = store_q ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (rsp_cnt == vl_q) state_nx = ST_DONE;
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q <= 1'b0;
      vl_q    <= '0;
      iss_cnt <= '0;
      rsp_cnt <= '0;
      out_cnt <= '0;
    end else if (accept) begin
      store_q <= cmd_store;
      vl_q    <= vl_clamped;
      iss_cnt <= '0;
      rsp_cnt <= '0;
      out_cnt <= '0;
    end else begin
      if (xfer)     iss_cnt <= iss_cnt + VL_W'(1);
      if (rsp_take) rsp_cnt <= rsp_cnt + VL_W'(1);
      // A load issue and a response in the same cycle cancel out.
      case ({ld_xfer, rsp_take})
        2'b10:   out_cnt <= out_cnt + OUT_W'(1);
        2'b01:   out_cnt <= out_cnt - OUT_W'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_vlsu_seq_ctrl.sv
// tb/tb_vlsu_seq_ctrl.sv - self-checking bench for vlsu_seq_ctrl
// Ports: none (top-level bench). Honours VLSU_STRIDE_EN when computing expected addresses.
module tb_vlsu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_store;
  logic [31:0] cmd_base;
  logic [31:0] cmd_stride;
  logic [4:0]  cmd_vl;
  logic [3:0]  st_idx;
  logic [31:0] st_data;
  logic        vrf_we;
  logic [3:0]  vrf_idx;
  logic [31:0] vrf_wdata;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] pend_data[$];
  int          pend_cyc[$];

  vlsu_seq_ctrl_if mem_bus ();

  always #5 clk = ~clk;

  // VRF read model: combinational data derived from the requested index.
  assign st_data = 32'h5A00_0000 + 32'(st_idx) * 32'd17;

  vlsu_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_store  (cmd_store),
    .cmd_base   (cmd_base),
    .cmd_stride (cmd_stride),
    .cmd_vl     (cmd_vl),
    .st_idx     (st_idx),
    .st_data    (st_data),
    .mem        (mem_bus),
    .vrf_we     (vrf_we),
    .vrf_idx    (vrf_idx),
    .vrf_wdata  (vrf_wdata),
    .busy       (busy),
    .done       (done)
  );

  function automatic logic [31:0] exp_step(input logic [31:0] stride);
`ifdef VLSU_STRIDE_EN
    return stride;
`else
    return 32'd4;
`endif
  endfunction

  task automatic send_cmd(input bit st, input logic [31:0] base, input logic [31:0] stride,
                          input int vl);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_store  = st;
    cmd_base   = base;
    cmd_stride = stride;
    cmd_vl     = 5'(vl);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_ready_offer: got %b want 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Drives one command to completion against a memory model; ready_mode 1 toggles ready
  // 1,0,1,...; responses come one cycle after issue but not before hold_n transfers.
  task automatic run_cmd(input bit st, input logic [31:0] base, input logic [31:0] stride,
                         input int vl, input int ready_mode, input int hold_n,
                         output int gated);
    int          exp_vl;
    int          m_iss, m_out, r_idx, n_xfer, done_cnt;
    bit          rsp, exp_v, xfer, prev_stall;
    logic [31:0] prev_addr, prev_wdata, ea, ed;
    exp_vl = (vl > 16) ? 16 : vl;
    for (int i = 0; i < exp_vl; i++) exp_addr_q.push_back(base + 32'(i) * exp_step(stride));
    pend_data.delete();
    pend_cyc.delete();
    m_iss = 0; m_out = 0; r_idx = 0; n_xfer = 0; done_cnt = 0; gated = 0;
    prev_stall = 1'b0; prev_addr = '0; prev_wdata = '0;
    send_cmd(st, base, stride, vl);
    for (int cyc = 0; cyc < 300 && done_cnt == 0; cyc++) begin
      mem_bus.mem_req_ready = (ready_mode == 0) ? 1'b1 : (cyc % 2 == 0);
      rsp = !st && pend_data.size() > 0 && n_xfer >= hold_n;
      if (rsp) rsp = pend_cyc[0] < cyc;
      mem_bus.mem_rsp_valid = rsp;
      mem_bus.mem_rsp_rdata = rsp ? pend_data[0] : 32'hDEAD_BEEF;
      #1;
      exp_v = (m_iss < exp_vl) && (st || m_out < 4);
      if (!exp_v && m_iss < exp_vl) gated++;
      checks++;
      if (mem_bus.mem_req_valid !== exp_v) begin
        failures++;
        $display("FAIL req_valid cyc=%0d: got %b want %b", cyc, mem_bus.mem_req_valid, exp_v);
      end
      if (prev_stall) begin
        checks++;
        if (mem_bus.mem_req_addr !== prev_addr || mem_bus.mem_req_wdata !== prev_wdata) begin
          failures++;
          $display("FAIL stall_hold: got %h/%h want %h/%h", mem_bus.mem_req_addr,
                   mem_bus.mem_req_wdata, prev_addr, prev_wdata);
        end
      end
      xfer       = mem_bus.mem_req_valid && mem_bus.mem_req_ready;
      prev_stall = mem_bus.mem_req_valid && !mem_bus.mem_req_ready;
      prev_addr  = mem_bus.mem_req_addr;
      prev_wdata = mem_bus.mem_req_wdata;
      if (xfer) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          failures++;
          $display("FAIL extra_xfer: got addr %h want none", mem_bus.mem_req_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          if (mem_bus.mem_req_addr !== ea) begin
            failures++;
            $display("FAIL addr: got %h want %h", mem_bus.mem_req_addr, ea);
          end
        end
        checks++;
        if (mem_bus.mem_req_we !== st) begin
          failures++;
          $display("FAIL req_we: got %b want %b", mem_bus.mem_req_we, st);
        end
        if (st) begin
          checks++;
          if (mem_bus.mem_req_wdata !== 32'h5A00_0000 + 32'(m_iss) * 32'd17) begin
            failures++;
            $display("FAIL wdata: got %h want %h", mem_bus.mem_req_wdata,
                     32'h5A00_0000 + 32'(m_iss) * 32'd17);
          end
        end else begin
          pend_data.push_back(32'hD000_0000 ^ (base + 32'(m_iss) * 32'h0101));
          pend_cyc.push_back(cyc);
        end
        n_xfer++;
      end
      checks++;
      if (vrf_we !== rsp) begin
        failures++;
        $display("FAIL vrf_we: got %b want %b", vrf_we, rsp);
      end
      if (rsp) begin
        ed = pend_data.pop_front();
        void'(pend_cyc.pop_front());
        checks++;
        if (vrf_idx !== 4'(r_idx) || vrf_wdata !== ed) begin
          failures++;
          $display("FAIL vrf_write: got %0d/%h want %0d/%h", vrf_idx, vrf_wdata, r_idx, ed);
        end
        r_idx++;
      end
      if (done === 1'b1) done_cnt++;
      if (xfer) m_iss++;
      if (xfer && !st) m_out++;
      if (rsp) m_out--;
      @(negedge clk);
    end
    mem_bus.mem_req_ready = 1'b0;
    mem_bus.mem_rsp_valid = 1'b0;
    #1;
    checks++;
    if (done_cnt != 1 || n_xfer != exp_vl || exp_addr_q.size() != 0 || pend_data.size() != 0) begin
      failures++;
      $display("FAIL completion: got done=%0d xfers=%0d left=%0d pend=%0d want 1/%0d/0/0",
               done_cnt, n_xfer, exp_addr_q.size(), pend_data.size(), exp_vl);
      exp_addr_q.delete();
    end
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL after_done: got done=%b ready=%b want 0/1", done, cmd_ready);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || vrf_we !== 1'b0 ||
        mem_bus.mem_req_valid !== 1'b0 || mem_bus.mem_req_addr !== 32'h0 ||
        mem_bus.mem_req_we !== 1'b0 || st_idx !== 4'h0 || vrf_idx !== 4'h0) begin
      failures++;
      $display("FAIL reset_state: got rdy=%b busy=%b done=%b vld=%b addr=%h want 1/0/0/0/0",
               cmd_ready, busy, done, mem_bus.mem_req_valid, mem_bus.mem_req_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unit_load();
    int g;
    run_cmd(1'b0, 32'h100, 32'd4, 4, 0, 0, g);
  endtask

  task automatic test_store_stall();
    int g;
    run_cmd(1'b1, 32'h400, 32'd4, 3, 1, 0, g);
  endtask

  task automatic test_max_out();
    int g;
    run_cmd(1'b0, 32'h800, 32'd4, 8, 0, 4, g);
    checks++;
    if (g == 0) begin
      failures++;
      $display("FAIL max_out_gate: got %0d gated cycles want >0", g);
    end
  endtask

  task automatic test_vl_zero();
    send_cmd(1'b0, 32'h300, 32'd4, 0);
    mem_bus.mem_req_ready = 1'b1;
    #1;
    checks++;
    if (mem_bus.mem_req_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL vl0_issue: got vld=%b done=%b busy=%b want 0/0/1",
               mem_bus.mem_req_valid, done, busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || mem_bus.mem_req_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL vl0_done: got done=%b vld=%b rdy=%b want 1/0/0",
               done, mem_bus.mem_req_valid, cmd_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL vl0_idle: got rdy=%b done=%b want 1/0", cmd_ready, done);
    end
    mem_bus.mem_req_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int g;
    run_cmd(1'b0, 32'hFFFF_FFF8, 32'd8, 3, 0, 0, g);
  endtask

  task automatic test_clamp();
    int g;
    run_cmd(1'b1, 32'h1000, 32'd4, 31, 0, 0, g);
  endtask

  task automatic test_reset_drain();
    send_cmd(1'b0, 32'h200, 32'd4, 2);
    mem_bus.mem_req_ready = 1'b1;
    mem_bus.mem_rsp_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || mem_bus.mem_req_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL drain_entry: got busy=%b vld=%b rdy=%b want 1/0/0",
               busy, mem_bus.mem_req_valid, cmd_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got rdy=%b busy=%b done=%b want 1/0/0", cmd_ready, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_bus.mem_rsp_valid = 1'b1;
      mem_bus.mem_rsp_rdata = 32'hBAD0_0000 + 32'(i);
      #1;
      checks++;
      if (vrf_we !== 1'b0) begin
        failures++;
        $display("FAIL stray_rsp %0d: got vrf_we=%b want 0", i, vrf_we);
      end
      @(negedge clk);
    end
    mem_bus.mem_rsp_valid = 1'b0;
  endtask

  initial begin
    rst_n                 = 1'b0;
    cmd_valid             = 1'b0;
    cmd_store             = 1'b0;
    cmd_base              = '0;
    cmd_stride            = '0;
    cmd_vl                = '0;
    mem_bus.mem_req_ready = 1'b0;
    mem_bus.mem_rsp_valid = 1'b0;
    mem_bus.mem_rsp_rdata = '0;
    test_reset();
    test_unit_load();
    test_store_stall();
    test_max_out();
    test_vl_zero();
    test_wrap();
    test_clamp();
    test_reset_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
